// File: rtl/uram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uram_pkg
// Description : Shared types, limits and the byte-merge helper for uram_sdp_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package uram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } init_state_t;

  localparam int MAX_READ_LATENCY = 4;

  // One byte lane: the write path and the write-first bypass both use this.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uram_sdp_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : uram_sdp_pipe_if
// Description : Write/read request bus and read-return signals of uram_sdp_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface uram_sdp_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
);

  logic                    i_we;
  logic [DATA_WIDTH/8-1:0] i_wbe;
  logic [ADDR_WIDTH-1:0]   i_wa;
  logic [DATA_WIDTH-1:0]   i_wd;
  logic                    i_re;
  logic [ADDR_WIDTH-1:0]   i_ra;
  logic                    o_rv;
  logic [DATA_WIDTH-1:0]   o_rd;
  logic                    o_ready;

  modport master (
    output i_we, i_wbe, i_wa, i_wd, i_re, i_ra,
    input  o_rv, o_rd, o_ready
  );

  modport slave (
    input  i_we, i_wbe, i_wa, i_wd, i_re, i_ra,
    output o_rv, o_rd, o_ready
  );

endinterface
`default_nettype wire

// File: rtl/uram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : uram_rd_pipe
// Description : Valid shift chain with enable-gated data registers (REGCE chain).
// Revision    : 1.0 - initial release
// ============================================================================
module uram_rd_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 1
) (
  input  logic                  clk2x,
  input  logic                  reset,
  input  logic                  i_v,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic                  o_rv,
  output logic [DATA_WIDTH-1:0] o_rd
);

  generate
    if (STAGES == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk2x ^ reset;
      assign o_rv     = i_v;
      assign o_rd     = i_d;
    end else begin : g_pipe
      logic [STAGES-1:0]     r_v;
      logic [DATA_WIDTH-1:0] r_d [STAGES];

      // Each data stage only moves when the stage before it holds a valid word.
      always_ff @(posedge clk2x) begin
        if (reset) begin
          r_v <= '0;
          for (int s = 0; s < STAGES; s++) begin
            r_d[s] <= '0;
          end
        end else begin
          r_v[0] <= i_v;
          if (i_v) begin
            r_d[0] <= i_d;
          end
          for (int s = 1; s < STAGES; s++) begin
            r_v[s] <= r_v[s-1];
            if (r_v[s-1]) begin
              r_d[s] <= r_d[s-1];
            end
          end
        end
      end

      assign o_rv = r_v[STAGES-1];
      assign o_rd = r_d[STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/uram_sdp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : uram_sdp_pipe
// Description : Simple-dual-port URAM model, byte writes, 1..4 cycle tracked read.
// Revision    : 1.0 - initial release
// ============================================================================
module uram_sdp_pipe
  import uram_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int RAM_DEPTH     = 4096,
  parameter int ADDR_WIDTH    = $clog2(RAM_DEPTH),
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_FIRST   = 0,
  parameter int INIT_ON_RESET = 0
) (
  input  logic          clk2x,
  input  logic          reset,
  uram_sdp_pipe_if.slave bus
);

  localparam int                  c_nbytes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] c_last   = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] c_one    = (ADDR_WIDTH+1)'(1);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("uram_sdp_pipe: READ_LATENCY must be within 1..4");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("uram_sdp_pipe: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  init_state_t           r_state;
  init_state_t           w_state_nxt;
  logic [ADDR_WIDTH:0]   r_sweep_cnt;
  logic [ADDR_WIDTH:0]   w_sweep_nxt;

  logic                  w_ready;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_collide;
  logic                  w_clearing;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  r_rv_s1;
  logic [DATA_WIDTH-1:0] r_rd_s1;

  // ------------------------------------------------------------------ init FSM
  always_ff @(posedge clk2x) begin
    if (reset) begin
      r_state     <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_cnt;
    case (r_state)
      CLEAR: begin
        if (r_sweep_cnt == c_last) begin
          w_state_nxt = IDLE;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_cnt + c_one;
        end
      end
      default: begin
      end
    endcase
  end

  assign w_ready     = (r_state == IDLE) && !reset;
  assign bus.o_ready = w_ready;

  // -------------------------------------------------------- write / collision
  assign w_wr_acc  = bus.i_we && w_ready;
  assign w_rd_acc  = bus.i_re && w_ready;
  assign w_collide = w_wr_acc && w_rd_acc && (bus.i_wa == bus.i_ra);
  assign w_wr_old  = r_mem[bus.i_wa];
  assign w_rd_old  = r_mem[bus.i_ra];

  generate
    for (genvar gb = 0; gb < c_nbytes; gb++) begin : g_byte
      assign w_merged[8*gb +: 8] = byte_merge(w_wr_old[8*gb +: 8], bus.i_wd[8*gb +: 8],
                                              bus.i_wbe[gb]);
    end
  endgenerate

  // On a collision the write address equals the read address, so the merged
  // write word is exactly the write-first read result.
  assign w_rd_word   = ((WRITE_FIRST != 0) && w_collide) ? w_merged : w_rd_old;

  assign w_clearing  = (r_state == CLEAR) && !reset;
  assign w_mem_we    = w_clearing || (w_wr_acc && (|bus.i_wbe));
  assign w_mem_addr  = w_clearing ? r_sweep_cnt[ADDR_WIDTH-1:0] : bus.i_wa;
  assign w_mem_wdata = w_clearing ? '0 : w_merged;

  always_ff @(posedge clk2x) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // ----------------------------------------------------- array output stage
  always_ff @(posedge clk2x) begin
    if (reset) begin
      r_rv_s1 <= 1'b0;
      r_rd_s1 <= '0;
    end else begin
      r_rv_s1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_s1 <= w_rd_word;
      end
    end
  end

  uram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (READ_LATENCY - 1)
  ) u_rd_pipe (
    .clk2x (clk2x),
    .reset (reset),
    .i_v   (r_rv_s1),
    .i_d   (r_rd_s1),
    .o_rv  (bus.o_rv),
    .o_rd  (bus.o_rd)
  );

endmodule
`default_nettype wire

// File: tb/tb_uram_sdp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_uram_sdp_pipe
// Description : Four uram_sdp_pipe configurations driven in parallel against a
//               word/queue level reference model, plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uram_sdp_pipe;

  localparam int DW    = 64;
  localparam int DEPTH = 100;
  localparam int AW    = 7;
  localparam int NI    = 4;
  localparam int LAT  [NI] = '{3, 4, 1, 2};
  localparam int WFST [NI] = '{0, 1, 1, 0};
  localparam int INIT [NI] = '{0, 0, 1, 1};

  typedef struct {
    int          due;
    logic [63:0] d;
    logic [7:0]  k;
  } rd_t;

  logic          clk2x = 1'b0;
  logic          reset = 1'b1;
  logic          s_we  = 1'b0;
  logic [7:0]    s_wbe = '0;
  logic [AW-1:0] s_wa  = '0;
  logic [63:0]   s_wd  = '0;
  logic          s_re  = 1'b0;
  logic [AW-1:0] s_ra  = '0;

  logic          o_rv_a  [NI];
  logic [63:0]   o_rd_a  [NI];
  logic          o_rdy_a [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk2x = ~clk2x;

  task automatic chk(input string nm, input int gi, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d got=%h want=%h", nm, gi, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] bmask(input logic [7:0] k);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int L  = LAT[gi];
      localparam int WF = WFST[gi];
      localparam int IN = INIT[gi];

      uram_sdp_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if ();

      assign u_if.i_we  = s_we;
      assign u_if.i_wbe = s_wbe;
      assign u_if.i_wa  = s_wa;
      assign u_if.i_wd  = s_wd;
      assign u_if.i_re  = s_re;
      assign u_if.i_ra  = s_ra;
      assign o_rv_a[gi]  = u_if.o_rv;
      assign o_rd_a[gi]  = u_if.o_rd;
      assign o_rdy_a[gi] = u_if.o_ready;

      uram_sdp_pipe #(
        .DATA_WIDTH    (DW),
        .RAM_DEPTH     (DEPTH),
        .ADDR_WIDTH    (AW),
        .READ_LATENCY  (L),
        .WRITE_FIRST   (WF),
        .INIT_ON_RESET (IN)
      ) u_dut (
        .clk2x (clk2x),
        .reset (reset),
        .bus   (u_if)
      );

      logic [63:0] m_mem   [DEPTH];
      logic [7:0]  m_known [DEPTH];
      rd_t         q[$];
      rd_t         e;
      logic [63:0] exp_rd = '0;
      logic [7:0]  exp_k  = '0;
      int          ec     = 0;
      int          low    = 0;
      bit          armed  = 1'b0;
      bit          erv;

      initial for (int a = 0; a < DEPTH; a++) m_known[a] = 8'h00;

      // Model: ready after DEPTH low-reset cycles when sweeping, reads return
      // the word as of the accepting edge, due L-1 edges later.
      always @(posedge clk2x) begin
        ec++;
        if (reset) begin
          q.delete();
          exp_rd = '0;
          exp_k  = 8'hFF;
          low    = 0;
          armed  = 1'b1;
        end else if (armed) begin
          if (IN == 0 || low >= DEPTH) begin
            if (s_re) begin
              e.due = ec + L - 1;
              e.d   = m_mem[s_ra];
              e.k   = m_known[s_ra];
              if (WF == 1 && s_we && s_wa == s_ra) begin
                e.d = merge(e.d, s_wd, s_wbe);
                e.k = e.k | s_wbe;
              end
              q.push_back(e);
            end
            if (s_we) begin
              m_mem[s_wa]   = merge(m_mem[s_wa], s_wd, s_wbe);
              m_known[s_wa] = m_known[s_wa] | s_wbe;
            end
          end
          if (IN == 1 && low == DEPTH - 1) begin
            for (int a = 0; a < DEPTH; a++) begin
              m_mem[a]   = '0;
              m_known[a] = 8'hFF;
            end
          end
          if (low < DEPTH) low++;
        end
      end

      always @(negedge clk2x) begin
        if (armed) begin
          chk("ready", gi, u_if.o_ready, !reset && (IN == 0 || low >= DEPTH));
          erv = 1'b0;
          if (q.size() > 0 && q[0].due == ec) begin
            exp_rd = q[0].d;
            exp_k  = q[0].k;
            erv    = 1'b1;
            void'(q.pop_front());
          end
          chk("rv", gi, u_if.o_rv, erv);
          chk("rd", gi, u_if.o_rd & bmask(exp_k), exp_rd & bmask(exp_k));
        end
      end
    end
  endgenerate

  task automatic step();
    @(posedge clk2x);
    #1;
  endtask

  task automatic idle();
    s_we = 1'b0;
    s_re = 1'b0;
  endtask

  task automatic wr(input int a, input logic [63:0] d, input logic [7:0] be);
    s_we = 1'b1; s_wa = AW'(a); s_wd = d; s_wbe = be; s_re = 1'b0;
    step();
    idle();
  endtask

  // Read (optionally with a same-cycle write), then watch one instance's output.
  task automatic rd_obs(input int gi, input int lat, input int a, input logic [63:0] expd,
                        input string nm, input bit cw, input logic [63:0] cwd,
                        input logic [7:0] cbe);
    s_re = 1'b1; s_ra = AW'(a);
    s_we = cw; s_wa = AW'(a); s_wd = cwd; s_wbe = cbe;
    step();
    idle();
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk2x);
      chk({nm, "_rv"}, gi, o_rv_a[gi], (k == lat) ? 64'd1 : 64'd0);
      if (k >= lat) chk({nm, "_rd"}, gi, o_rd_a[gi], expd);
    end
    step();
  endtask

  task automatic rnd(input int n);
    for (int i = 0; i < n; i++) begin
      s_we = ($urandom_range(0, 2) != 0);
      s_wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                         : AW'($urandom_range(0, DEPTH - 1));
      s_wd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       s_wbe = 8'hFF;
        1:       s_wbe = 8'h00;
        default: s_wbe = 8'($urandom);
      endcase
      s_re = ($urandom_range(0, 2) != 0);
      s_ra = ($urandom_range(0, 3) == 0) ? s_wa : AW'($urandom_range(0, DEPTH - 1));
      step();
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    idle();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk2x);
    chk("rst_rd", 0, o_rd_a[0], 64'h0);
    chk("rst_rv", 1, o_rv_a[1], 64'h0);
    chk("rst_ready_noinit", 0, o_rdy_a[0], 64'h1);
    chk("rst_ready_init", 2, o_rdy_a[2], 64'h0);
    step();

    // Traffic during the sweep: dropped by the sweeping instances.
    rnd(60);
    cnt = 0;
    while (!o_rdy_a[2] && cnt < 200) begin
      step();
      cnt++;
    end
    chk("sweep_done", 2, o_rdy_a[2], 64'h1);

    for (int a = 0; a < DEPTH; a++) wr(a, {$urandom, $urandom}, 8'hFF);

    wr(5, 64'h1122334455667788, 8'hFF);
    rd_obs(0, 3, 5, 64'h1122334455667788, "lat3", 1'b0, '0, '0);

    wr(9, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    wr(9, 64'h0, 8'h0F);
    rd_obs(0, 3, 9, 64'hFFFFFFFF00000000, "wbe", 1'b0, '0, '0);

    wr(2, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    rd_obs(0, 3, 2, 64'hAAAAAAAAAAAAAAAA, "coll_rf", 1'b1, 64'h5555555555555555, 8'h01);
    rd_obs(0, 3, 2, 64'hAAAAAAAAAAAAAA55, "coll_after", 1'b0, '0, '0);
    wr(2, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    rd_obs(1, 4, 2, 64'hAAAAAAAAAAAAAA55, "coll_wf", 1'b1, 64'h5555555555555555, 8'h01);

    for (int a = 0; a < 16; a++) begin
      s_re = 1'b1;
      s_ra = AW'(a);
      step();
    end
    idle();
    repeat (6) step();

    rnd(1500);
    repeat (6) step();

    // Reset one cycle after a read is accepted: nothing may emerge.
    s_re = 1'b1; s_ra = AW'(5);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk2x);
      chk("rstrd_rv", 1, o_rv_a[1], 64'h0);
      chk("rstrd_rd", 1, o_rd_a[1], 64'h0);
    end
    step();

    // Reset in the middle of the sweep: the full sweep must repeat.
    repeat (33) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk2x);
      if (o_rdy_a[2]) break;
      cnt++;
    end
    chk("sweep_len", 2, 64'(cnt), 64'd100);
    step();

    rd_obs(2, 1, 0, 64'h0, "zero0", 1'b0, '0, '0);
    rd_obs(3, 2, 99, 64'h0, "zero99", 1'b0, '0, '0);

    rnd(300);
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
